mem_request_unit: RTL and testbench

- Initiator-side sequencer for the processor's synchronous single-port RAM. It accepts one load/store request from the datapath (MAR/MDR side) over a valid/ready handshake.
- It drives the RAM's read/write/address/data_in pins for exactly one cycle and captures the registered read data one cycle later.
- It returns a response over a valid/ready handshake and sits between the control unit/datapath and the RAM.

---
 rtl/mem_request_unit.sv | 112 +++++++++++
 tb/tb_mem_request_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_request_unit.sv
// Load/store sequencer for the single-port registered-output RAM. Optional MEM_BOUNDS_CHECK_EN rejects addresses >= MEM_DEPTH.
// Latency from accept: store response in cycle 2, load in cycle 3, rejected address in cycle 1.
// One request in flight: req_ready only in IDLE; response held stable until resp_ready.
module mem_request_unit #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 512,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q;
  logic   accept;
  logic   addr_bad;
  logic   resp_done;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = MEM_DEPTH[ADDR_W:0];
  assign addr_bad = ({1'b0, req_addr} >= DEPTH_L);
`else
  assign addr_bad = 1'b0;
`endif

  assign req_ready   = (state_q == S_IDLE);
  assign ram_read    = (state_q == S_RD);
  assign ram_write   = (state_q == S_WR);
  assign resp_valid  = (state_q == S_RESP);
  assign ram_address = req_q.addr;
  assign ram_data_in = req_q.wdata;
  assign accept      = req_valid && req_ready;
  assign resp_done   = resp_valid && resp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (addr_bad)       state_d = S_RESP;
          else if (req_write) state_d = S_WR;
          else                state_d = S_RD;
        end
      end
      S_RD:    state_d = S_CAP;
      S_CAP:   state_d = S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      rd_count   <= '0;
      wr_count   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q    <= '{write: req_write, addr: req_addr, wdata: req_wdata};
        resp_err <= addr_bad;
        if (addr_bad) resp_rdata <= '0;
      end
      if (state_q == S_CAP) resp_rdata <= ram_data_out;
      if (state_q == S_WR)  resp_rdata <= '0;
      // Rejected accesses never touched the RAM, so they are not counted
      if (resp_done && !resp_err) begin
        if (req_q.write) begin
          if (wr_count != '1) wr_count <= wr_count + 1'b1;
        end else begin
          if (rd_count != '1) rd_count <= rd_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_request_unit.sv
// Randomized bench for mem_request_unit against a transaction-level memory/counter model.
module tb_mem_request_unit;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 256;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid, resp_ready = 1'b0;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err, ram_read, ram_write;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in, ram_data_out;
  logic [CNT_W-1:0]  rd_count, wr_count;
  logic              ram_init = 1'b1;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] model_mem [512];
  int exp_rd = 0, exp_wr = 0;

  mem_request_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with registered read data
  logic [DATA_W-1:0] ram_mem [512];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) ram_mem[i] <= '0;
      ram_data_out <= '0;
    end else begin
      if (ram_write) ram_mem[ram_address] <= ram_data_in;
      if (ram_read)  ram_data_out <= ram_mem[ram_address];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [ADDR_W-1:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    return int'(a) >= DEPTH;
`else
    return (a != a);
`endif
  endfunction

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_rd_count"}, 32'(rd_count), 32'(sat(exp_rd)));
    check({tag, "_wr_count"}, 32'(wr_count), 32'(sat(exp_wr)));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_req_ready", 32'(req_ready), 32'd1);
  endtask

  // Issue one request at a negedge and complete it, holding resp_ready low for `hold` cycles
  task automatic run_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input int hold);
    int lat = 0, nrd = 0, nwr = 0, want_lat;
    bit bad;
    logic [DATA_W-1:0] want_data;
    bad = is_bad(a);
    want_lat = bad ? 1 : (wr ? 2 : 3);
    want_data = (bad || wr) ? '0 : model_mem[a];
    wait_ready();
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = ADDR_W'($urandom); req_wdata = $urandom;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      if (ram_read && ram_write) check("strobe_overlap", 32'd1, 32'd0);
      if (ram_read) begin
        nrd++;
        check("rd_addr", 32'(ram_address), 32'(a));
      end
      if (ram_write) begin
        nwr++;
        check("wr_addr", 32'(ram_address), 32'(a));
        check("wr_data", ram_data_in, d);
      end
      if (resp_valid) lat = c;
      else @(negedge clk);
    end
    check("latency", 32'(lat), 32'(want_lat));
    check("ram_read_pulses", 32'(nrd), (bad || wr) ? 32'd0 : 32'd1);
    check("ram_write_pulses", 32'(nwr), (!bad && wr) ? 32'd1 : 32'd0);
    for (int i = 0; i < hold; i++) begin
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, want_data);
      check("hold_err", 32'(resp_err), 32'(bad));
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_strobes", 32'({ram_read, ram_write}), 32'd0);
      @(negedge clk);
    end
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_rdata", resp_rdata, want_data);
    check("resp_err", 32'(resp_err), 32'(bad));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    if (!bad) begin
      if (wr) begin
        model_mem[a] = d;
        exp_wr++;
      end else begin
        exp_rd++;
      end
    end
    check("post_req_ready", 32'(req_ready), 32'd1);
    check("post_resp_valid", 32'(resp_valid), 32'd0);
    check_counts("post");
  endtask

  logic [ADDR_W-1:0] pool [6];

  initial begin
    for (int i = 0; i < 512; i++) model_mem[i] = '0;
    pool[0] = 9'h090; pool[1] = 9'h0F7; pool[2] = 9'h013;
    pool[3] = 9'h1FF; pool[4] = 9'h100; pool[5] = 9'h0FF;

    // Reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    rst_n = 1'b1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_strobes", 32'({ram_read, ram_write}), 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_data_in", ram_data_in, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check_counts("rst");

    run_req(1'b1, 9'h090, 32'hDEADBEEF, 0);
    run_req(1'b0, 9'h090, 32'h0, 0);
    run_req(1'b0, 9'h090, 32'h0, 5);
    run_req(1'b0, 9'h100, 32'h0, 1);

    // Reset lands on the edge that ends WR
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h0F7; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    check("midwr_ram_write", 32'(ram_write), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_mem[9'h0F7] = 32'h12345678;
    exp_rd = 0;
    exp_wr = 0;
    for (int i = 0; i < 4; i++) begin
      check("midwr_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    check("midwr_ram_content", ram_mem[9'h0F7], 32'h12345678);
    check("midwr_addr_cleared", 32'(ram_address), 32'd0);
    check_counts("midwr");
    run_req(1'b0, 9'h0F7, 32'h0, 0);

    // Random traffic, long enough to saturate the narrow counters
    for (int t = 0; t < 60; t++) begin
      run_req(1'($urandom), pool[$urandom_range(0, 5)], $urandom, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
